// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
//   fetch_state_t : fetch FSM state encodings
//   if_id_t       : IF/ID pipeline payload {valid, instr, pc_inc}
//   pc_next()     : 16-bit modulo PC increment
package fetch_unit_pkg;

    localparam int unsigned XLEN    = 16;
    localparam int unsigned IF_ID_W = 1 + 2 * XLEN;
    localparam logic [XLEN-1:0] RESET_PC = 16'h0000;
    localparam logic [XLEN-1:0] PC_STEP  = 16'h0002;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        SKID   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_inc;
    } if_id_t;

    // Wraps naturally at 16 bits: 16'hFFFE -> 16'h0000.
    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with a valid bit in the MSB; shared by IF/ID and ID/EX.
//   clk, rst_n : clock, async active-low reset (clears all bits)
//   load       : capture d
//   hold       : keep q when not loading
//   flush      : clear valid; overrides load and hold
//   d, q       : {valid, payload}
module if_id_reg #(
    parameter int unsigned W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         hold,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Neither load nor hold inserts a bubble; payload bits are left as-is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q[W-1] <= 1'b0;
        end else if (load) begin
            q <= d;
        end else if (!hold) begin
            q[W-1] <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem request handshake,
// fills IF/ID, applies resteers/flushes, skids on decode stalls, stops on HALT.
//   clk, rst_n                       : clock, async active-low reset
//   IF_rewrite_pc, IF_pc_rewrite_to  : resteer request and target
//   flush_if2id                      : invalidate IF/ID
//   ID_stall, ID_halt                : decode hold / HALT decoded
//   imem_req, imem_addr              : fetch request (combinational)
//   imem_done, imem_rdata            : fetch completion pulse and data
//   ID_valid, ID_instr, ID_pc_inc    : registered IF/ID contents
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IF_rewrite_pc,
    input  logic [15:0] IF_pc_rewrite_to,
    input  logic        flush_if2id,
    input  logic        ID_stall,
    input  logic        ID_halt,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_done,
    input  logic [15:0] imem_rdata,
    output logic        ID_valid,
    output logic [15:0] ID_instr,
    output logic [15:0] ID_pc_inc
);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [XLEN-1:0] drain_addr, drain_addr_n;
    logic [XLEN-1:0] skid_instr, skid_instr_n;
    logic [XLEN-1:0] skid_pc_inc, skid_pc_inc_n;
    logic            halt_pending, halt_pending_n;
    logic            open_req;
    logic            ifid_load, ifid_hold, ifid_flush;
    if_id_t          ifid_d, ifid_q;

    // DRAIN keeps presenting the squashed address until its done returns.
    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = (state == DRAIN) ? drain_addr : pc;
    assign open_req  = imem_req && !imem_done;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            drain_addr   <= RESET_PC;
            skid_instr   <= '0;
            skid_pc_inc  <= '0;
            halt_pending <= 1'b0;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            drain_addr   <= drain_addr_n;
            skid_instr   <= skid_instr_n;
            skid_pc_inc  <= skid_pc_inc_n;
            halt_pending <= halt_pending_n;
        end
    end

    // Next state, PC and IF/ID control; priority resteer > halt > stall > normal.
    always_comb begin
        state_n        = state;
        pc_n           = pc;
        drain_addr_n   = drain_addr;
        skid_instr_n   = skid_instr;
        skid_pc_inc_n  = skid_pc_inc;
        halt_pending_n = halt_pending;
        ifid_load      = 1'b0;
        ifid_hold      = ID_stall;
        ifid_d         = if_id_t'{valid: 1'b1, instr: imem_rdata, pc_inc: pc_next(pc)};

        if (state == HALTED) begin
            ifid_hold = 1'b0;
        end else if (IF_rewrite_pc) begin
            // Any done this cycle belongs to the wrong path and is dropped.
            pc_n           = IF_pc_rewrite_to;
            halt_pending_n = 1'b0;
            state_n        = open_req ? DRAIN : FETCH;
            if (state == FETCH) begin
                drain_addr_n = pc;
            end
        end else if (ID_halt) begin
            ifid_hold = 1'b0;
            if (open_req) begin
                state_n        = DRAIN;
                halt_pending_n = 1'b1;
                if (state == FETCH) begin
                    drain_addr_n = pc;
                end
            end else begin
                state_n = HALTED;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem_done) begin
                        pc_n = pc_next(pc);
                        if (!ID_stall) begin
                            ifid_load = 1'b1;
                        end else begin
                            skid_instr_n  = imem_rdata;
                            skid_pc_inc_n = pc_next(pc);
                            state_n       = SKID;
                        end
                    end
                end
                SKID: begin
                    if (!ID_stall) begin
                        ifid_d    = if_id_t'{valid: 1'b1, instr: skid_instr, pc_inc: skid_pc_inc};
                        ifid_load = 1'b1;
                        state_n   = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_done) begin
                        state_n = halt_pending ? HALTED : FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ifid_flush = flush_if2id || (state == HALTED);

    if_id_reg #(.W(IF_ID_W)) u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ifid_load),
        .hold  (ifid_hold),
        .flush (ifid_flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign ID_valid  = ifid_q.valid;
    assign ID_instr  = ifid_q.instr;
    assign ID_pc_inc = ifid_q.pc_inc;

endmodule
